// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two per-requester byte FIFOs sharing one UART serializer.
// Round-robin source selection; a four-state FSM hands over one byte per frame.
module uart_tx_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk_uart,
    input  logic                   areset_uart,
    input  logic                   req0_valid,
    input  logic [DATA_W-1:0]      req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [DATA_W-1:0]      req1_data,
    output logic                   req1_ready,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    input  logic                   tx_busy,
    output logic                   grant_id,
    output logic [$clog2(DEPTH):0] count0,
    output logic [$clog2(DEPTH):0] count1,
    output logic                   ovf0,
    output logic                   ovf1
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [2][DEPTH];
    logic [AW-1:0]     wptr_q [2];
    logic [AW-1:0]     rptr_q [2];
    logic [AW:0]       cnt_q [2];
    logic [1:0]        ovf_q;
    logic [1:0]        valid, ready, push, pop, nonempty;
    logic [DATA_W-1:0] wdata [2];
    logic [DATA_W-1:0] head [2];
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              sel;
    logic [DATA_W-1:0] data_q, data_d;

    assign valid    = {req1_valid, req0_valid};
    assign wdata[0] = req0_data;
    assign wdata[1] = req1_data;
    assign head[0]  = mem_q[0][rptr_q[0]];
    assign head[1]  = mem_q[1][rptr_q[1]];
    // DEPTH is a power of two, so the count MSB is set exactly when full.
    assign ready    = {~cnt_q[1][AW], ~cnt_q[0][AW]};
    assign nonempty = {|cnt_q[1], |cnt_q[0]};
    assign push     = valid & ready;

    always_ff @(posedge clk_uart or posedge areset_uart) begin
        if (areset_uart) begin
            for (int i = 0; i < 2; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
                if (pop[i])  rptr_q[i] <= rptr_q[i] + AW'(1);
                if (push[i] && !pop[i]) cnt_q[i] <= cnt_q[i] + (AW + 1)'(1);
                else if (!push[i] && pop[i]) cnt_q[i] <= cnt_q[i] - (AW + 1)'(1);
                if (valid[i] && !ready[i]) ovf_q[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_uart) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem_q[i][wptr_q[i]] <= wdata[i];
        end
    end

    always_ff @(posedge clk_uart or posedge areset_uart) begin
        if (areset_uart) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        data_d       = data_q;
        pop          = '0;
        // On a tie the requester that did not send last wins.
        sel = (nonempty[0] && nonempty[1]) ? ~last_grant_q : nonempty[1];
        case (state_q)
            StIdle: begin
                if (|nonempty) begin
                    pop     = sel ? 2'b10 : 2'b01;
                    grant_d = sel;
                    data_d  = head[sel];
                    state_d = StStart;
                end
            end
            StStart:    state_d = StWaitBusy;
            StWaitBusy: if (tx_busy) state_d = StWaitDone;
            StWaitDone: begin
                if (!tx_busy) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default:    state_d = StIdle;
        endcase
    end

    assign tx_start   = (state_q == StStart);
    assign tx_data    = data_q;
    assign grant_id   = grant_q;
    assign count0     = cnt_q[0];
    assign count1     = cnt_q[1];
    assign ovf0       = ovf_q[0];
    assign ovf1       = ovf_q[1];
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run scored
// against a queue-level model of the two FIFOs and the round-robin rule.
module tb_uart_tx_arbiter;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, v0, v1, r0, r1, tx_start, tx_busy, grant_id, ovf0, ovf1;
    logic [7:0] d0, d1, tx_data;
    logic [2:0] count0, count1;

    int         n_run = 0;
    int         n_fail = 0;
    int         busy_len = 2;
    bit         hold = 1'b0;
    int         ser_left = 0;
    logic [7:0] cap_data[$];
    logic       cap_gid[$];

    uart_tx_arbiter #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk_uart(clk), .areset_uart(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
        .count0(count0), .count1(count1), .ovf0(ovf0), .ovf1(ovf1)
    );

    always #5 clk = ~clk;

    // Serializer model: captures each tx_start and stays busy for busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ser_left = 0;
                cap_data.delete();
                cap_gid.delete();
            end else if (tx_start) begin
                cap_data.push_back(tx_data);
                cap_gid.push_back(grant_id);
                ser_left = busy_len;
            end else if (ser_left > 0) begin
                ser_left--;
            end
            tx_busy = hold || (ser_left > 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        busy_len = 20;
        for (int k = 0; k < 4; k++) begin
            v0 = 1'b1; d0 = 8'h41 + 8'(k);
            @(negedge clk);
        end
        v0 = 1'b0;
        repeat (2) @(negedge clk);
        n_run++;
        if (count0 !== 3'd3) begin
            n_fail++; $display("FAIL rst_pre_count0: got %0d expected 3", count0);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_run++;
        if ({tx_start, tx_data, grant_id} !== 10'd0) begin
            n_fail++;
            $display("FAIL rst_tx_outputs: got start=%0b data=%02h gid=%0b expected 0/00/0",
                     tx_start, tx_data, grant_id);
        end
        n_run++;
        if ({count0, count1, ovf0, ovf1, r0, r1} !== 10'b000_000_0_0_1_1) begin
            n_fail++;
            $display("FAIL rst_fifo_outputs: got c0=%0d c1=%0d ovf=%0b%0b rdy=%0b%0b expected 0 0 00 11",
                     count0, count1, ovf0, ovf1, r0, r1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_run++;
        if (cap_data.size() != 0 || count0 !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_after_release: got starts=%0d count0=%0d expected 0 0",
                     cap_data.size(), count0);
        end
        // Reset landing during the start pulse must kill it at once.
        v0 = 1'b1; d0 = 8'h5A;
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        n_run++;
        if (tx_start !== 1'b1) begin
            n_fail++; $display("FAIL rst_start_pre: got tx_start=%0b expected 1", tx_start);
        end
        #2 rst = 1'b1;
        #1;
        n_run++;
        if (tx_start !== 1'b0) begin
            n_fail++; $display("FAIL rst_start_drop: got tx_start=%0b expected 0", tx_start);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        busy_len = 10;
        v0 = 1'b1; d0 = 8'hA5;
        @(negedge clk);
        v0 = 1'b0;
        n_run++;
        if (tx_start !== 1'b0 || count0 !== 3'd1) begin
            n_fail++;
            $display("FAIL single_e0: got start=%0b count0=%0d expected 0 1", tx_start, count0);
        end
        @(negedge clk);
        n_run++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL single_e1: got start=%0b data=%02h gid=%0b expected 1 a5 0",
                     tx_start, tx_data, grant_id);
        end
        @(negedge clk);
        n_run++;
        if (tx_start !== 1'b0) begin
            n_fail++; $display("FAIL single_e2: got tx_start=%0b expected 0", tx_start);
        end
        repeat (40) @(negedge clk);
        n_run++;
        if (cap_data.size() != 1) begin
            n_fail++; $display("FAIL single_count: got %0d starts expected 1", cap_data.size());
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [4];
        logic       exp_g [4];
        exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h11; exp_d[3] = 8'h21;
        exp_g[0] = 1'b0;  exp_g[1] = 1'b1;  exp_g[2] = 1'b0;  exp_g[3] = 1'b1;
        do_reset();
        busy_len = 3;
        v0 = 1'b1; d0 = 8'h10; v1 = 1'b1; d1 = 8'h20;
        @(negedge clk);
        d0 = 8'h11; d1 = 8'h21;
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        for (int k = 0; k < 200 && cap_data.size() < 4; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        n_run++;
        if (cap_data.size() != 4) begin
            n_fail++; $display("FAIL rr_count: got %0d starts expected 4", cap_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_run++;
            if (i >= cap_data.size()) begin
                n_fail++; $display("FAIL rr_missing: byte %0d never sent", i);
            end else if (cap_data[i] !== exp_d[i] || cap_gid[i] !== exp_g[i]) begin
                n_fail++;
                $display("FAIL rr_byte%0d: got %02h/gid%0b expected %02h/gid%0b",
                         i, cap_data[i], cap_gid[i], exp_d[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        busy_len = 2; hold = 1'b1;
        v0 = 1'b1; d0 = 8'h77;
        @(negedge clk);
        v0 = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_run++;
            if (r1 !== (k < 4)) begin
                n_fail++; $display("FAIL ovf_ready%0d: got %0b expected %0b", k, r1, k < 4);
            end
            v1 = 1'b1; d1 = 8'hB0 + 8'(k);
            @(negedge clk);
        end
        v1 = 1'b0;
        n_run++;
        if (count1 !== 3'd4 || r1 !== 1'b0 || ovf1 !== 1'b1 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_state: got c1=%0d rdy1=%0b ovf1=%0b ovf0=%0b expected 4 0 1 0",
                     count1, r1, ovf1, ovf0);
        end
        hold = 1'b0;
        for (int k = 0; k < 300 && cap_data.size() < 5; k++) @(negedge clk);
        repeat (30) @(negedge clk);
        n_run++;
        if (cap_data.size() != 5) begin
            n_fail++; $display("FAIL ovf_count: got %0d starts expected 5", cap_data.size());
        end
        for (int i = 1; i < 5; i++) begin
            n_run++;
            if (i >= cap_data.size()) begin
                n_fail++; $display("FAIL ovf_missing: byte %0d never sent", i);
            end else if (cap_data[i] !== 8'hB0 + 8'(i - 1) || cap_gid[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_byte%0d: got %02h/gid%0b expected %02h/gid1",
                         i, cap_data[i], cap_gid[i], 8'hB0 + 8'(i - 1));
            end
        end
    endtask

    task automatic test_simul_push_pop();
        do_reset();
        busy_len = 2; hold = 1'b1;
        v0 = 1'b1; d0 = 8'h30;
        @(negedge clk);
        d0 = 8'h31;
        @(negedge clk);
        d0 = 8'h32;
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        n_run++;
        if (count0 !== 3'd2) begin
            n_fail++; $display("FAIL simul_pre: got count0=%0d expected 2", count0);
        end
        hold = 1'b0;
        repeat (2) @(negedge clk);
        v0 = 1'b1; d0 = 8'h33;
        @(negedge clk);
        v0 = 1'b0;
        n_run++;
        if (count0 !== 3'd2 || tx_start !== 1'b1 || tx_data !== 8'h31) begin
            n_fail++;
            $display("FAIL simul_pop: got c0=%0d start=%0b data=%02h expected 2 1 31",
                     count0, tx_start, tx_data);
        end
        for (int k = 0; k < 200 && cap_data.size() < 4; k++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_run++;
            if (i >= cap_data.size()) begin
                n_fail++; $display("FAIL simul_missing: byte %0d never sent", i);
            end else if (cap_data[i] !== 8'h30 + 8'(i)) begin
                n_fail++;
                $display("FAIL simul_byte%0d: got %02h expected %02h", i, cap_data[i],
                         8'h30 + 8'(i));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int b = 0; b < 12; b++) begin
            busy_len = $urandom_range(2, 4);
            for (int k = 0; k < 100 && !r0; k++) @(negedge clk);
            v0 = r0; d0 = 8'hC0 + 8'(b);
            @(negedge clk);
            v0 = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int k = 0; k < 500 && cap_data.size() < 12; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        n_run++;
        if (cap_data.size() != 12 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d starts ovf0=%0b expected 12 0",
                     cap_data.size(), ovf0);
        end
        for (int i = 0; i < 12; i++) begin
            n_run++;
            if (i >= cap_data.size()) begin
                n_fail++; $display("FAIL wrap_missing: byte %0d never sent", i);
            end else if (cap_data[i] !== 8'hC0 + 8'(i)) begin
                n_fail++;
                $display("FAIL wrap_byte%0d: got %02h expected %02h", i, cap_data[i],
                         8'hC0 + 8'(i));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] mq0[$];
        logic [7:0] mq1[$];
        logic [7:0] pd0, pd1, exp_d;
        bit         pa0, pa1, po0, po1, movf0, movf1, last, w;
        int         seen, pushed;
        do_reset();
        last = 1'b1; seen = 0; pushed = 0;
        pa0 = 0; pa1 = 0; po0 = 0; po1 = 0; movf0 = 0; movf1 = 0;
        pd0 = '0; pd1 = '0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            // Frames popped at the last edge see only pushes from earlier edges.
            while (seen < cap_data.size()) begin
                n_run++;
                if (mq0.size() == 0 && mq1.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious: got start data=%02h expected no start",
                             cap_data[seen]);
                end else begin
                    w = (mq0.size() != 0 && mq1.size() != 0) ? !last : (mq0.size() == 0);
                    exp_d = w ? mq1.pop_front() : mq0.pop_front();
                    if (cap_gid[seen] !== w || cap_data[seen] !== exp_d) begin
                        n_fail++;
                        $display("FAIL rand_frame%0d: got %02h/gid%0b expected %02h/gid%0b",
                                 seen, cap_data[seen], cap_gid[seen], exp_d, w);
                    end
                    last = w;
                end
                seen++;
            end
            if (pa0) mq0.push_back(pd0);
            if (pa1) mq1.push_back(pd1);
            movf0 = movf0 | po0; movf1 = movf1 | po1;
            pa0 = 0; pa1 = 0; po0 = 0; po1 = 0;
            n_run++;
            if (int'(count0) != mq0.size() || int'(count1) != mq1.size()) begin
                n_fail++;
                $display("FAIL rand_count: got %0d/%0d expected %0d/%0d",
                         count0, count1, mq0.size(), mq1.size());
            end
            n_run++;
            if (r0 !== (mq0.size() < DEPTH) || r1 !== (mq1.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL rand_ready: got %0b%0b expected %0b%0b", r0, r1,
                         mq0.size() < DEPTH, mq1.size() < DEPTH);
            end
            n_run++;
            if (ovf0 !== movf0 || ovf1 !== movf1) begin
                n_fail++;
                $display("FAIL rand_ovf: got %0b%0b expected %0b%0b", ovf0, ovf1, movf0, movf1);
            end
            if (cyc < 500) begin
                busy_len = $urandom_range(2, 6);
                v0 = ($urandom_range(0, 6) == 0); d0 = 8'($urandom);
                v1 = ($urandom_range(0, 6) == 0); d1 = 8'($urandom);
                if (v0) begin
                    if (mq0.size() < DEPTH) begin pa0 = 1; pd0 = d0; pushed++; end
                    else po0 = 1;
                end
                if (v1) begin
                    if (mq1.size() < DEPTH) begin pa1 = 1; pd1 = d1; pushed++; end
                    else po1 = 1;
                end
            end else begin
                v0 = 1'b0; v1 = 1'b0;
            end
        end
        n_run++;
        if (seen != pushed) begin
            n_fail++; $display("FAIL rand_total: got %0d frames expected %0d", seen, pushed);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_simul_push_pop();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
